// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry buffer between instruction memory and decode. Flush wins over
// push/pop; a push into a full buffer is accepted only when the same cycle pops.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Output is forced to zero when empty so stale words never leak to decode.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; cleared by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; when full with a simultaneous pop, wr_ptr equals rd_ptr and
  // the slot being overwritten is the one leaving on this same edge.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: sequential PC generation, 2-entry decode buffer,
// redirect handling and a sticky fault on misaligned redirect targets.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | not fetching; buffered words are kept and still drain
// ST_FETCH | push {fetch_pc, imem_rdata} whenever the buffer has room
// ST_HALT  | end of memory or fault; only a redirect (without fault) or reset leaves
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               IMEM_WORDS = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              halted,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] PC_LIMIT  = ADDR_W'(4 * IMEM_WORDS);
  localparam logic [ADDR_W-1:0] PC_RESET  = {RESET_PC[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] PC_STRIDE = ADDR_W'(4);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] fetch_pc_d;
  logic              fault_q;
  logic              fault_d;

  logic              push;
  logic              pop;
  logic              flush;
  logic              buf_full;
  logic              buf_empty;
  logic              in_range;
  fetch_entry_t      wr_entry;
  fetch_entry_t      rd_entry;

  assign in_range   = (fetch_pc_q < PC_LIMIT);
  assign inst_valid = ~buf_empty;
  assign pop        = inst_valid & inst_ready;
  assign wr_entry   = '{pc: fetch_pc_q, inst: imem_rdata};

  assign imem_addr  = fetch_pc_q;
  assign inst_data  = rd_entry.inst;
  assign inst_pc    = rd_entry.pc;
  assign halted     = (state_q == ST_HALT) & buf_empty;
  assign fault      = fault_q;

  // State, fetch PC and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= PC_RESET;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state and push decision; redirect overrides everything until a fault.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fault_d    = fault_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect && !fault_q) begin
      flush = 1'b1;
      if (is_word_aligned(redirect_pc)) begin
        fetch_pc_d = redirect_pc;
        state_d    = ST_FETCH;
      end else begin
        fault_d = 1'b1;
        state_d = ST_HALT;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (!in_range) begin
            state_d = ST_HALT;
          end else if (!en) begin
            state_d = ST_IDLE;
          end else if (!buf_full || pop) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STRIDE;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (buf_full),
    .empty (buf_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a transfer scoreboard. Memory word n holds n.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;
  logic        fault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] exp_pc;
  int          cyc;

  logic        hold_v = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_data;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr >> 2;

  fetch_unit #(.IMEM_WORDS(64), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .halted      (halted),
    .fault       (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue n sequential words as expected transfers, accept until consumed.
  task automatic drain(input int n, input int budget, output int cycles);
    int i;
    for (int k = 0; k < n; k++) begin
      q.push_back('{pc: exp_pc, data: exp_pc >> 2});
      exp_pc = exp_pc + 32'd4;
    end
    inst_ready = 1'b1;
    for (i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    #1;
    inst_ready = 1'b0;
    cycles = i;
    check("drain_left", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  // Monitor: score every transfer and verify the head holds while stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check1("hold_valid", inst_valid, 1'b1);
          check("hold_pc", inst_pc, hold_pc);
          check("hold_data", inst_data, hold_data);
        end
        if (inst_valid && inst_ready) begin
          if (q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_xfer: got inst_pc %h, expected no transfer", inst_pc);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("xfer_pc", inst_pc, e.pc);
            check("xfer_data", inst_data, e.data);
          end
        end
        hold_v    = inst_valid && !inst_ready && !redirect;
        hold_pc   = inst_pc;
        hold_data = inst_data;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
    step(2);
    check1("rst_valid", inst_valid, 1'b0);
    check1("rst_halted", halted, 1'b0);
    check1("rst_fault", fault, 1'b0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_data", inst_data, 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    // Sequential stream, fill latency and throughput
    rst_n = 1'b1; en = 1'b1;
    step(1);
    check1("fill_idle", inst_valid, 1'b0);
    step(1);
    check1("fill_valid", inst_valid, 1'b1);
    check("fill_pc", inst_pc, 32'h0);
    exp_pc = 32'h0;
    drain(6, 40, cyc);
    check("thru_cycles", 32'(cyc), 32'd6);

    // Stall: buffer holds two words, fetch stops
    step(5);
    check("stall_pc", inst_pc, 32'd24);
    check("stall_addr", imem_addr, 32'd32);
    drain(4, 40, cyc);

    // Redirect while full
    step(2);
    check("pre_rd_pc", inst_pc, 32'd40);
    redirect = 1'b1; redirect_pc = 32'h38;
    step(1);
    redirect = 1'b0;
    check1("rd_flush", inst_valid, 1'b0);
    check("rd_addr", imem_addr, 32'h38);
    step(1);
    check1("rd_valid", inst_valid, 1'b1);
    check("rd_first_pc", inst_pc, 32'h38);
    exp_pc = 32'h38;
    drain(48, 200, cyc);

    // End of memory: halt after draining
    step(4);
    check1("halt_busy", halted, 1'b0);
    check1("halt_drain_v", inst_valid, 1'b1);
    check("halt_drain_pc", inst_pc, 32'd248);
    check("halt_addr", imem_addr, 32'd256);
    drain(2, 20, cyc);
    check1("halted", halted, 1'b1);
    check1("halted_v", inst_valid, 1'b0);
    step(3);
    check("halted_addr", imem_addr, 32'd256);

    // Redirect out of HALT
    redirect = 1'b1; redirect_pc = 32'h0;
    step(1);
    redirect = 1'b0;
    check1("resume_halted", halted, 1'b0);
    check("resume_addr", imem_addr, 32'h0);
    exp_pc = 32'h0;
    drain(3, 20, cyc);
    step(2);

    // Misaligned redirect: sticky fault
    redirect = 1'b1; redirect_pc = 32'h06;
    step(1);
    redirect = 1'b0;
    check1("fault_set", fault, 1'b1);
    check1("fault_halted", halted, 1'b1);
    check1("fault_flush", inst_valid, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h40;
    step(1);
    redirect = 1'b0; inst_ready = 1'b1;
    step(3);
    inst_ready = 1'b0;
    check1("fault_sticky", fault, 1'b1);
    check1("fault_ignore_h", halted, 1'b1);
    check1("fault_ignore_v", inst_valid, 1'b0);

    // Reset clears fault; reset with two buffered words
    rst_n = 1'b0;
    step(1);
    check1("rst2_fault", fault, 1'b0);
    rst_n = 1'b1;
    step(2);
    exp_pc = 32'h0;
    drain(2, 20, cyc);
    step(2);
    check("buf2_pc", inst_pc, 32'd8);
    check("buf2_data", inst_data, 32'd2);
    check("buf2_addr", imem_addr, 32'd16);
    #2;
    rst_n = 1'b0;
    #1;
    check1("arst_valid", inst_valid, 1'b0);
    check("arst_pc", inst_pc, 32'h0);
    check("arst_data", inst_data, 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2);
    check1("post_rst_valid", inst_valid, 1'b1);
    check("post_rst_pc", inst_pc, 32'h0);
    exp_pc = 32'h0;
    drain(2, 20, cyc);

    step(2);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
